// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive deframer and the transmit-side
// serializer: the framing FSM state encoding and the 8N1 / 16x oversampling
// constants.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Framing FSM states shared by the receive and transmit paths.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Oversample ticks per bit period.
  localparam int UART_OVERSAMPLE = 16;
  // Data bits per character (LSB first).
  localparam int UART_DATA_BITS  = 8;
  // Tick count within the start bit at which its middle is reached.
  localparam int UART_MID_SAMPLE = 8;

  // Counter widths derived from the constants above.
  localparam int UART_TC_W = $clog2(UART_OVERSAMPLE);
  localparam int UART_BC_W = $clog2(UART_DATA_BITS);

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Small first-word fall-through FIFO holding received bytes until the OS
// side pops them. A pop and a push in the same cycle are both honoured; the
// pop is considered first, so a push into a full FIFO is accepted when a pop
// happens in the same cycle. Pops while empty are ignored.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset (empties the FIFO)
//   push   in   write din this cycle
//   pop    in   discard the head entry this cycle
//   din    in   WIDTH  byte to write
//   head   out  WIDTH  oldest entry, all zeros when empty
//   count  out  $clog2(DEPTH)+1  number of entries held
//   full   out  count == DEPTH
//   empty  out  count == 0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags, qualified push/pop and fall-through head.
  always_comb begin
    empty   = (count == {CNT_W{1'b0}});
    full    = (count == CNT_FULL);
    do_pop  = pop & ~empty;
    // A same-cycle pop frees the slot the push needs.
    do_push = push & (~full | do_pop);
    if (empty) begin
      head = {WIDTH{1'b0}};
    end else begin
      head = mem[rd_ptr];
    end
  end

  // Storage array write; contents are only visible through head when valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy counter kept separately from the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CNT_W{1'b0}};
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : uart_rx_fifo

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// Receive half of the NIC-to-NIC UART link. Synchronizes the serial rx line,
// oversamples it 16x, deframes 8N1 characters (LSB first) and queues good
// bytes in a small FIFO that the OS side drains with read_nic.
//
// Parameters:
//   OVERSAMPLE_DIV  clk cycles per oversample tick (>= 2)
//   FIFO_DEPTH      receive FIFO entries (power of two, >= 2)
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   rx          in   asynchronous serial input, idle high
//   read_nic    in   pop strobe, one byte per cycle while non-empty
//   data_out    out  8  FIFO head byte, 8'h00 when empty (registered)
//   read_nic_i  out  interrupt level, high while bytes are queued (registered)
//   rx_count    out  $clog2(FIFO_DEPTH)+1  bytes queued (registered)
//   frame_err   out  one-cycle pulse: stop bit low, byte dropped
//   overrun     out  one-cycle pulse: FIFO full with no pop, byte dropped
// ---------------------------------------------------------------------------
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE_DIV = 27,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  input  logic                         read_nic,
  output logic [7:0]                   data_out,
  output logic                         read_nic_i,
  output logic [$clog2(FIFO_DEPTH):0]  rx_count,
  output logic                         frame_err,
  output logic                         overrun
);

  localparam int DIV_W = $clog2(OVERSAMPLE_DIV);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0]     DIV_LAST    = DIV_W'(OVERSAMPLE_DIV - 1);
  localparam logic [UART_TC_W-1:0] TC_MID_LAST = UART_TC_W'(UART_MID_SAMPLE - 1);
  localparam logic [UART_TC_W-1:0] TC_BIT_LAST = UART_TC_W'(UART_OVERSAMPLE - 1);
  localparam logic [UART_BC_W-1:0] BC_LAST     = UART_BC_W'(UART_DATA_BITS - 1);

  // Synchronizer
  logic rx_meta;
  logic rx_s;

  // FSM and datapath
  uart_state_t          state;
  uart_state_t          state_next;
  logic [DIV_W-1:0]     div;
  logic [UART_TC_W-1:0] tc;
  logic [UART_BC_W-1:0] bc;
  logic [7:0]           shift;

  // FSM decoded strobes
  logic tick;
  logic mid_sample;
  logic bit_sample;
  logic stop_sample;
  logic push;
  logic stop_bad;

  // FIFO interface
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Two-flop synchronizer; presets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        // A line that is high again mid start bit was only a glitch.
        if (mid_sample) begin
          state_next = rx_s ? IDLE : DATA;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (bit_sample && (bc == BC_LAST)) begin
          state_next = STOP;
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (stop_sample) begin
          state_next = IDLE;
        end else begin
          state_next = STOP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: oversample tick and the sampling / push strobes.
  always_comb begin
    tick        = 1'b0;
    mid_sample  = 1'b0;
    bit_sample  = 1'b0;
    stop_sample = 1'b0;
    push        = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        tick = 1'b0;
      end
      START: begin
        tick       = (div == DIV_LAST);
        mid_sample = tick && (tc == TC_MID_LAST);
      end
      DATA: begin
        tick       = (div == DIV_LAST);
        bit_sample = tick && (tc == TC_BIT_LAST);
      end
      STOP: begin
        tick        = (div == DIV_LAST);
        stop_sample = tick && (tc == TC_BIT_LAST);
        push        = stop_sample & rx_s;
        stop_bad    = stop_sample & ~rx_s;
      end
      default: begin
        tick = 1'b0;
      end
    endcase
  end

  // Tick divider: held at zero in IDLE so it restarts on the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= {DIV_W{1'b0}};
    end else if ((state == IDLE) || tick) begin
      div <= {DIV_W{1'b0}};
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Tick counter within a bit; realigned to the bit grid at mid start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= {UART_TC_W{1'b0}};
    end else if ((state == IDLE) || mid_sample) begin
      tc <= {UART_TC_W{1'b0}};
    end else if (tick) begin
      tc <= tc + UART_TC_W'(1);
    end else begin
      tc <= tc;
    end
  end

  // Data bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc <= {UART_BC_W{1'b0}};
    end else if (state == IDLE) begin
      bc <= {UART_BC_W{1'b0}};
    end else if (bit_sample) begin
      bc <= bc + UART_BC_W'(1);
    end else begin
      bc <= bc;
    end
  end

  // Shift register: new bit enters at the MSB so the first (LSB) ends at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= 8'h00;
    end else if (bit_sample) begin
      shift <= {rx_s, shift[7:1]};
    end else begin
      shift <= shift;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (read_nic),
    .din   (shift),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Error pulses, one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      // A same-cycle pop makes room, so only a pop-less full FIFO overruns.
      overrun   <= push & fifo_full & ~read_nic;
    end
  end

  // Registered OS-facing view of the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= 8'h00;
      read_nic_i <= 1'b0;
      rx_count   <= {CNT_W{1'b0}};
    end else begin
      data_out   <= fifo_head;
      read_nic_i <= ~fifo_empty;
      rx_count   <= fifo_count;
    end
  end

endmodule : uart_rx_deframer

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
// Self-checking bench for uart_rx_deframer with OVERSAMPLE_DIV=4. Stimulus
// drives 8N1 frames on rx; a reference model (byte queue + expected event
// queue) is updated when each frame is issued, and a monitor process
// compares the DUT's FIFO output and error pulses against it.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

  localparam int DIV          = 4;
  localparam int DEPTH        = 4;
  localparam int BIT_CYC      = DIV * 16;
  localparam int FRAME_CYC    = BIT_CYC * 10;
  localparam int LATENCY      = 152 * DIV + 4;
  localparam int STOP_POP_CYC = LATENCY - 2;
  localparam int EV_FE        = 0;
  localparam int EV_OV        = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       read_nic;
  logic       stim_pop = 1'b0;
  logic       mon_pop = 1'b0;
  logic       drain_en = 1'b0;
  logic [7:0] data_out;
  logic       read_nic_i;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q[$];
  int         err_q[$];
  int         rise_at;

  assign read_nic = stim_pop | mon_pop;

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .OVERSAMPLE_DIV (DIV),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .read_nic   (read_nic),
    .data_out   (data_out),
    .read_nic_i (read_nic_i),
    .rx_count   (rx_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one frame (or its first ncyc cycles); call at a negedge.
  // A full frame updates the reference model before any bits are sent.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int ncyc, input logic pop_at_stop);
    logic [9:0] fr;
    fr = {stop_bit, data, 1'b0};
    if (ncyc == FRAME_CYC) begin
      if (!stop_bit) err_q.push_back(EV_FE);
      else if (model_q.size() >= DEPTH && !pop_at_stop) err_q.push_back(EV_OV);
      else model_q.push_back(data);
    end
    rise_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (read_nic_i && rise_at < 0) rise_at = c;
      rx = fr[c / BIT_CYC];
      stim_pop = pop_at_stop && (c == STOP_POP_CYC);
      if (pop_at_stop && c == STOP_POP_CYC) begin
        check("head_at_stop_pop", 32'(data_out), 32'(model_q[0]));
        void'(model_q.pop_front());
      end
      @(negedge clk);
    end
    stim_pop = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && model_q.size() > 0; i++) @(negedge clk);
    check("drain_done", 32'(model_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("drain_count", 32'(rx_count), 32'd0);
    check("drain_irq", 32'(read_nic_i), 32'd0);
  endtask

  // Monitor: error pulses against the expected event queue, and FIFO
  // output against the model byte queue whenever draining is enabled.
  initial begin
    logic prev_fe;
    logic prev_ov;
    int   hold;
    prev_fe = 1'b0;
    prev_ov = 1'b0;
    hold    = 0;
    forever begin
      @(negedge clk);
      mon_pop = 1'b0;
      if (rst) begin
        prev_fe = 1'b0;
        prev_ov = 1'b0;
        hold    = 0;
      end else begin
        if (frame_err) begin
          check("frame_err_width", 32'(prev_fe), 32'd0);
          if (err_q.size() == 0) check("frame_err_unexpected", 32'd1, 32'd0);
          else check("frame_err_kind", 32'(err_q.pop_front()), 32'(EV_FE));
        end
        if (overrun) begin
          check("overrun_width", 32'(prev_ov), 32'd0);
          if (err_q.size() == 0) check("overrun_unexpected", 32'd1, 32'd0);
          else check("overrun_kind", 32'(err_q.pop_front()), 32'(EV_OV));
        end
        prev_fe = frame_err;
        prev_ov = overrun;
        if (hold > 0) begin
          hold--;
        end else if (drain_en && read_nic_i) begin
          if (model_q.size() == 0) check("rx_unexpected_byte", 32'(data_out), 32'h100);
          else check("rx_byte", 32'(data_out), 32'(model_q.pop_front()));
          mon_pop = 1'b1;
          hold    = 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic any_rise;
    logic [7:0] d;
    logic       sb;
    int         gap;

    // Reset state and long idle line.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_irq", 32'(read_nic_i), 32'd0);
    check("rst_count", 32'(rx_count), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    any_rise = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      any_rise = any_rise | read_nic_i | frame_err | overrun | (rx_count != 3'd0);
    end
    check("idle_quiet", 32'(any_rise), 32'd0);

    // Single frame: latency and pop.
    send_frame(8'hA5, 1'b1, FRAME_CYC, 1'b0);
    check("a5_latency", 32'(rise_at), 32'(LATENCY));
    check("a5_data", 32'(data_out), 32'h0A5);
    check("a5_count", 32'(rx_count), 32'd1);
    stim_pop = 1'b1;
    @(negedge clk);
    stim_pop = 1'b0;
    void'(model_q.pop_front());
    @(negedge clk);
    check("pop_data_zero", 32'(data_out), 32'd0);
    check("pop_irq_low", 32'(read_nic_i), 32'd0);
    check("pop_count", 32'(rx_count), 32'd0);

    // Back-to-back fill, overrun, then push-with-pop at the stop sample.
    send_frame(8'h01, 1'b1, FRAME_CYC, 1'b0);
    send_frame(8'h80, 1'b1, FRAME_CYC, 1'b0);
    send_frame(8'hFF, 1'b1, FRAME_CYC, 1'b0);
    send_frame(8'h00, 1'b1, FRAME_CYC, 1'b0);
    check("fill_count", 32'(rx_count), 32'd4);
    check("fill_head", 32'(data_out), 32'h001);
    send_frame(8'h3C, 1'b1, FRAME_CYC, 1'b0);
    check("overrun_seen", 32'(err_q.size()), 32'd0);
    check("overrun_count", 32'(rx_count), 32'd4);
    send_frame(8'h3C, 1'b1, FRAME_CYC, 1'b1);
    check("stop_pop_count", 32'(rx_count), 32'd4);
    check("stop_pop_head", 32'(data_out), 32'h080);
    drain_en = 1'b1;
    wait_drain();
    drain_en = 1'b0;

    // Framing error then a good frame.
    send_frame(8'h55, 1'b0, FRAME_CYC, 1'b0);
    check("fe_seen", 32'(err_q.size()), 32'd0);
    check("fe_count", 32'(rx_count), 32'd0);
    send_frame(8'h12, 1'b1, FRAME_CYC, 1'b0);
    check("after_fe_count", 32'(rx_count), 32'd1);
    check("after_fe_data", 32'(data_out), 32'h012);
    drain_en = 1'b1;
    wait_drain();

    // Start-bit glitch is rejected, and the next frame still arrives.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_count", 32'(rx_count), 32'd0);
    send_frame(8'h96, 1'b1, FRAME_CYC, 1'b0);
    wait_drain();

    // Reset in the middle of a character.
    drain_en = 1'b0;
    send_frame(8'hC3, 1'b1, 5 * BIT_CYC, 1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    model_q.delete();
    err_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_count", 32'(rx_count), 32'd0);
    send_frame(8'h7E, 1'b1, FRAME_CYC, 1'b0);
    check("midrst_7e_count", 32'(rx_count), 32'd1);
    check("midrst_7e_data", 32'(data_out), 32'h07E);
    drain_en = 1'b1;
    wait_drain();

    // Randomized frames with occasional bad stop bits and idle gaps.
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 100);
      send_frame(d, sb, FRAME_CYC, 1'b0);
      check("rand_events", 32'(err_q.size()), 32'd0);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_deframer

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive half of the UART link between two NIC controllers: samples the serial `rx` line at 16x oversampling, deframes 8N1 characters (1 start, 8 data LSB-first, 1 stop), and queues each good byte in a small FIFO. The OS-side logic drains that FIFO through a `read_nic` pop strobe and is alerted by the `read_nic_i` interrupt level. Sits beside the transmit path inside the NIC controller, fed directly by the peer's `tx` wire.

## Interface
- `OVERSAMPLE_DIV`, 27: clk cycles per oversample tick (50 MHz / (115200 × 16) ≈ 27); must be ≥ 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock (MAX10 50 MHz domain).
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `read_nic`  in  1  pop strobe; one byte is consumed per cycle it is high and the FIFO is non-empty.
- `data_out`  out  8  FIFO head byte (first-word fall-through); 8'h00 when empty.
- `read_nic_i`  out  1  interrupt level; high while the FIFO is non-empty.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- `overrun`  out  1  one-cycle pulse: good byte arrived with FIFO full and no pop; byte discarded.

## Operation
- Reset values: `data_out`=0, `read_nic_i`=0, `rx_count`=0, `frame_err`=0, `overrun`=0; FIFO emptied; FSM in IDLE; synchronizer flops preset to 1; tick divider and counters cleared. A reset mid-character abandons it with no output.
- `rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- Tick divider counts 0..OVERSAMPLE_DIV-1 and emits `tick` on terminal count; it is held cleared in IDLE and restarts at 0 on the start edge.
- FSM states:
  - IDLE: on `rx_s`=0 → START, clear tick counter `tc` (4 bits) and bit counter `bc` (3 bits).
  - START: at the 8th tick (mid start bit), `rx_s`=1 → IDLE (glitch rejected, no output); `rx_s`=0 → DATA, `tc`=0.
  - DATA: every 16th tick sample `rx_s` into shift register MSB, shift right (LSB first); after `bc`=7 sample → STOP.
  - STOP: at the 16th tick sample `rx_s`. 1 → push byte (or `overrun` if full without same-cycle pop); 0 → `frame_err`, no push. Either way → IDLE.
- FIFO: when a pop and push occur in the same cycle, the pop is applied first, so a push when full is accepted if `read_nic` is also high. `read_nic` while empty is ignored; `rx_count` stays 0. Pointers wrap modulo FIFO_DEPTH, with count kept as a separate counter.
- Back-to-back characters are supported: IDLE is re-entered at mid stop bit, so the next start edge is caught with no gap.

## Timing
- Start-edge detection: IDLE→START occurs 3 cycles after the `rx` pin falls (2 synchronizer flops + 1 registered compare).
- From START entry to the stop sample: (8 + 8×16 + 16) = 152 ticks = 152×OVERSAMPLE_DIV cycles.
- Push occurs on the stop-sample cycle. `read_nic_i`, `rx_count`, and `data_out` update on the following edge. Total from the `rx` falling edge is 152×OVERSAMPLE_DIV + 4 cycles.
- `frame_err` and `overrun` are high for exactly one cycle, the cycle after the stop sample.
- Pop: `data_out` shows the next entry (or 0) and `rx_count` decrements on the edge after `read_nic` is sampled high.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum {IDLE, START, DATA, STOP};
  - `UART_OVERSAMPLE`=16;
  - `UART_DATA_BITS`=8;
  - `UART_MID_SAMPLE`=8.
- The transmit-side serializer imports the same package.
- One sub-module, `uart_rx_fifo`, parameterised by depth, with push, pop, head, count, and full/empty outputs. Synchronizer, divider, FSM, and shift register stay in `uart_rx_deframer`.

## Test plan
All scenarios use OVERSAMPLE_DIV=4.
- Reset then idle-high `rx` for 2000 cycles → all outputs 0, `read_nic_i` never rises.
- Drive 8N1 frame 8'hA5 at 64 cycles per bit → `read_nic_i` rises exactly 152×4+4 cycles after the start edge, `data_out`=8'hA5, `rx_count`=1. Pulse `read_nic` → `data_out`=0, `read_nic_i`=0.
- Send 0x01, 0x80, 0xFF, 0x00 back-to-back with no idle gap and no pops → FIFO holds them in order and `rx_count`=4. Send a 5th byte 0x3C → `overrun` pulses once and `rx_count` stays 4. Repeat, asserting `read_nic` on the stop-sample cycle → 0x3C is accepted and `overrun` stays low.
- Frame 8'h55 with the stop bit driven low → `frame_err` is a single-cycle pulse and `rx_count` is unchanged. The next good frame 8'h12 is received correctly.
- 20-cycle low glitch on idle `rx` → FSM returns to IDLE at the mid-start sample, with no push and no error pulse.
- Assert `rst` mid-way through the data bits of 8'hC3, then send 8'h7E → only 8'h7E is queued and `rx_count`=1.
